// File: rtl/cpu_controller.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB, owning PC, IR and the datapath strobes.
// Define CPU_HALT_EN to decode an all-ones instruction as HALT (stop until reset).
module cpu_controller #(
    parameter int MemSize  = 10,
    parameter int DataSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DataSize-1:0] instruction,
    input  logic                hold,
    output logic [MemSize-1:0]  PC,
    output logic                IM_read,
    output logic                IM_write,
    output logic                IM_enable,
    output logic [DataSize-1:0] ir,
    output logic [3:0]          alu_op,
    output logic                imm_sel,
    output logic                exec_en,
    output logic                wb_en,
    output logic                illegal,
    output logic                halted
);

`ifdef CPU_HALT_EN
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;
`endif

    typedef struct packed {
        logic       illegal;
        logic       imm_sel;
        logic [3:0] alu_op;
    } decode_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_ROTR = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;

    state_t  state;
    decode_t dec;
    logic    dec_halt;

    // Unknown encodings come back with alu_op=0 and imm_sel=0 alongside the illegal flag.
    function automatic decode_t decode(input logic [5:0] opcode, input logic [4:0] sub);
        decode_t d;
        d = '0;
        case (opcode)
            6'b101000: begin d.alu_op = OP_ADD; d.imm_sel = 1'b1; end
            6'b101100: begin d.alu_op = OP_OR;  d.imm_sel = 1'b1; end
            6'b101011: begin d.alu_op = OP_XOR; d.imm_sel = 1'b1; end
            6'b100010: begin d.alu_op = OP_MOV; d.imm_sel = 1'b1; end
            6'b100000: begin
                case (sub)
                    5'b00000: d.alu_op = OP_ADD;
                    5'b00001: d.alu_op = OP_SUB;
                    5'b00010: d.alu_op = OP_AND;
                    5'b00100: d.alu_op = OP_OR;
                    5'b00011: d.alu_op = OP_XOR;
                    5'b01000: begin d.alu_op = OP_SLL;  d.imm_sel = 1'b1; end
                    5'b01001: begin d.alu_op = OP_SRL;  d.imm_sel = 1'b1; end
                    5'b01011: begin d.alu_op = OP_ROTR; d.imm_sel = 1'b1; end
                    default:  d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    // Decoding the IM bus during DECODE lets the registered fields line up with ir from EXEC on.
    always_comb dec = decode(instruction[30:25], instruction[4:0]);

`ifdef CPU_HALT_EN
    logic halt_pending;
    assign dec_halt = &instruction;
`else
    assign dec_halt = 1'b0;
    assign halted   = 1'b0;
`endif

    // IM_read follows hold in the same cycle so a stalled fetch never strobes the memory.
    assign IM_read  = (state == FETCH) && !hold;
    assign IM_write = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            PC        <= '0;
            ir        <= '0;
            IM_enable <= 1'b0;
            exec_en   <= 1'b0;
            wb_en     <= 1'b0;
            illegal   <= 1'b0;
            alu_op    <= 4'd0;
            imm_sel   <= 1'b0;
`ifdef CPU_HALT_EN
            halt_pending <= 1'b0;
            halted       <= 1'b0;
`endif
        end else begin
            exec_en <= 1'b0;
            wb_en   <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    IM_enable <= 1'b1;
                end
                FETCH: begin
                    if (!hold) state <= DECODE;
                end
                DECODE: begin
                    ir      <= instruction;
                    alu_op  <= dec.alu_op;
                    imm_sel <= dec.imm_sel;
                    illegal <= dec.illegal && !dec_halt;
                    exec_en <= !dec.illegal;
`ifdef CPU_HALT_EN
                    halt_pending <= dec_halt;
`endif
                    state   <= EXEC;
                end
                EXEC: begin
`ifdef CPU_HALT_EN
                    if (halt_pending) begin
                        state     <= HALT;
                        IM_enable <= 1'b0;
                        halted    <= 1'b1;
                    end else
`endif
                    begin
                        state <= WB;
                        wb_en <= !illegal;
                    end
                end
                WB: begin
                    PC      <= PC + MemSize'(1);
                    illegal <= 1'b0;
                    state   <= FETCH;
                end
`ifdef CPU_HALT_EN
                HALT: state <= HALT;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a table-driven program checked through a fetch-to-execute scoreboard,
// plus directed reset, hold, illegal/halt and PC-wrap sequences.
module tb_cpu_controller;
    localparam int MW       = 10;
    localparam int DW       = 32;
    localparam int IM_DEPTH = 1 << MW;
    localparam int PROG_LEN = 21;

    localparam logic [5:0] OP_ALU1 = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b101000;
    localparam logic [5:0] OP_ORI  = 6'b101100;
    localparam logic [5:0] OP_XORI = 6'b101011;
    localparam logic [5:0] OP_MOVI = 6'b100010;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  alu;
        logic        imm;
        logic        ill;
        logic        skip;
    } vec_t;

    typedef struct {
        logic [3:0]    alu;
        logic          imm;
        logic          ill;
        logic [MW-1:0] pc;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          hold;
    logic [DW-1:0] instruction;
    logic [MW-1:0] PC;
    logic          IM_read, IM_write, IM_enable;
    logic [DW-1:0] ir;
    logic [3:0]    alu_op;
    logic          imm_sel, exec_en, wb_en, illegal, halted;

    vec_t imem[IM_DEPTH];
    vec_t prog[PROG_LEN];
    sb_t  scoreQ[$];

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int wbCount     = 0;
    int lastWb      = 0;
    bit lastWbValid, checkSpacing, pendingWb, pendingIll, prevIllegal;

    cpu_controller #(.MemSize(MW), .DataSize(DW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .hold(hold),
        .PC(PC), .IM_read(IM_read), .IM_write(IM_write), .IM_enable(IM_enable),
        .ir(ir), .alu_op(alu_op), .imm_sel(imm_sel), .exec_en(exec_en),
        .wb_en(wb_en), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [24:0] low);
        return {1'b0, op, low};
    endfunction

    function automatic vec_t vec(input logic [31:0] w, input logic [3:0] a, input logic i, input logic il);
        vec_t v;
        v = '{word: w, alu: a, imm: i, ill: il, skip: 1'b0};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
        end
    endtask

    // One clock: fetch model (data valid the cycle after IM_read), scoreboard push/pop, strobe checks.
    task automatic tick();
        logic          rd;
        logic [MW-1:0] addr;
        sb_t           e;
        int            sum;
        #2;
        rd   = IM_read;
        addr = PC;
        @(posedge clk);
        #1;
        cycle++;
        if (rd) begin
            instruction = imem[addr].word;
            if (!imem[addr].skip)
                scoreQ.push_back('{alu: imem[addr].alu, imm: imem[addr].imm, ill: imem[addr].ill, pc: addr});
        end
        sum = int'(exec_en) + int'(wb_en) + int'(IM_read);
        checkOutput("strobe_exclusive", 32'(sum <= 1), 32'd1);
        if (pendingWb) begin
            checkOutput("wb_en", 32'(wb_en), 32'(!pendingIll));
            checkOutput("illegal_in_wb", 32'(illegal), 32'(pendingIll));
            pendingWb = 1'b0;
        end else if (wb_en) begin
            checkOutput("wb_unexpected", 32'(wb_en), 32'd0);
        end
        if (exec_en || (illegal && !prevIllegal)) begin
            if (scoreQ.size() == 0) begin
                checkOutput("sb_underflow", 32'(scoreQ.size()), 32'd1);
            end else begin
                e = scoreQ.pop_front();
                checkOutput("alu_op", 32'(alu_op), 32'(e.alu));
                checkOutput("imm_sel", 32'(imm_sel), 32'(e.imm));
                checkOutput("illegal", 32'(illegal), 32'(e.ill));
                checkOutput("exec_en", 32'(exec_en), 32'(!e.ill));
                checkOutput("pc_in_exec", 32'(PC), 32'(e.pc));
                pendingWb  = 1'b1;
                pendingIll = e.ill;
            end
        end
        if (wb_en) begin
            if (checkSpacing && lastWbValid) checkOutput("wb_spacing", 32'(cycle - lastWb), 32'd4);
            lastWb      = cycle;
            lastWbValid = 1'b1;
            wbCount++;
        end
        prevIllegal = illegal;
    endtask

    task automatic clearTracking();
        scoreQ.delete();
        pendingWb   = 1'b0;
        prevIllegal = 1'b0;
        wbCount     = 0;
        lastWbValid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        hold  = 1'b0;
        clearTracking();
        repeat (3) tick();
        clearTracking();
    endtask

    // Memory gets NOPs (SRLI r0,r0,0) everywhere, then the first n table entries.
    task automatic applyStimulus(input int n);
        for (int a = 0; a < IM_DEPTH; a++) imem[a] = vec(mk(OP_ALU1, 25'd9), 4'd6, 1'b1, 1'b0);
        for (int k = 0; k < n; k++) imem[k] = prog[k];
    endtask

    initial begin
        int guard;
        reset       = 1'b1;
        hold        = 1'b0;
        instruction = '0;

        prog[0]  = vec(mk(OP_ADDI, 25'd13),       4'd0, 1'b1, 1'b0);
        prog[1]  = vec(mk(OP_MOVI, 25'h0001234),  4'd8, 1'b1, 1'b0);
        prog[2]  = vec(mk(OP_ALU1, 25'h00210C0),  4'd0, 1'b0, 1'b0);
        prog[3]  = vec(mk(OP_ALU1, 25'h0000021),  4'd1, 1'b0, 1'b0);
        prog[4]  = vec(mk(OP_ALU1, 25'h0000042),  4'd2, 1'b0, 1'b0);
        prog[5]  = vec(mk(OP_ALU1, 25'h0000084),  4'd3, 1'b0, 1'b0);
        prog[6]  = vec(mk(OP_ALU1, 25'h0000063),  4'd4, 1'b0, 1'b0);
        prog[7]  = vec(mk(OP_ALU1, 25'h0000108),  4'd5, 1'b1, 1'b0);
        prog[8]  = vec(mk(OP_ALU1, 25'h000000B),  4'd7, 1'b1, 1'b0);
        prog[9]  = vec(mk(OP_ORI,  25'h00000FF),  4'd3, 1'b1, 1'b0);
        prog[10] = vec(mk(OP_XORI, 25'h1FFFFFF),  4'd4, 1'b1, 1'b0);
        prog[11] = vec(mk(OP_ALU1, 25'h0000009),  4'd6, 1'b1, 1'b0);
        prog[12] = vec(mk(OP_ADDI, 25'h000001F) | 32'h8000_0000, 4'd0, 1'b1, 1'b0);
        prog[13] = vec(mk(OP_MOVI, 25'h1FFFFFF),  4'd8, 1'b1, 1'b0);
        prog[14] = vec(mk(OP_ALU1, 25'h1FFFFE0),  4'd0, 1'b0, 1'b0);
        prog[15] = vec(mk(OP_ALU1, 25'h1FFFFE1),  4'd1, 1'b0, 1'b0);
        prog[16] = vec(mk(OP_ALU1, 25'h1FFFFE2),  4'd2, 1'b0, 1'b0);
        prog[17] = vec(mk(OP_ALU1, 25'h1FFFFE4),  4'd3, 1'b0, 1'b0);
        prog[18] = vec(mk(OP_ALU1, 25'h1FFFFE3),  4'd4, 1'b0, 1'b0);
        prog[19] = vec(mk(OP_ALU1, 25'h1FFFFE8),  4'd5, 1'b1, 1'b0);
        prog[20] = vec(mk(OP_ALU1, 25'h1FFFFEB),  4'd7, 1'b1, 1'b0);

        $display("[TB] reset state and first instruction timing");
        applyStimulus(PROG_LEN);
        doReset();
        checkOutput("rst_PC", 32'(PC), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_IM_enable", 32'(IM_enable), 32'd0);
        checkOutput("rst_IM_read", 32'(IM_read), 32'd0);
        checkOutput("rst_IM_write", 32'(IM_write), 32'd0);
        checkOutput("rst_exec_en", 32'(exec_en), 32'd0);
        checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("c1_IM_read", 32'(IM_read), 32'd0);
        checkOutput("c1_IM_enable", 32'(IM_enable), 32'd0);
        tick();
        checkOutput("c2_IM_read", 32'(IM_read), 32'd1);
        checkOutput("c2_IM_enable", 32'(IM_enable), 32'd1);
        tick();
        checkOutput("c3_IM_read", 32'(IM_read), 32'd0);
        checkOutput("c3_exec_en", 32'(exec_en), 32'd0);
        tick();
        checkOutput("c4_exec_en", 32'(exec_en), 32'd1);
        checkOutput("c4_alu_op", 32'(alu_op), 32'd0);
        checkOutput("c4_imm_sel", 32'(imm_sel), 32'd1);
        checkOutput("c4_ir", ir, prog[0].word);
        tick();
        checkOutput("c5_wb_en", 32'(wb_en), 32'd1);
        checkOutput("c5_exec_en", 32'(exec_en), 32'd0);
        tick();
        checkOutput("c6_PC", 32'(PC), 32'd1);
        checkOutput("c6_wb_en", 32'(wb_en), 32'd0);

        $display("[TB] 21-instruction program");
        applyStimulus(PROG_LEN);
        doReset();
        reset        = 1'b0;
        checkSpacing = 1'b1;
        guard        = 0;
        while (wbCount < PROG_LEN && guard < 200) begin tick(); guard++; end
        checkOutput("prog_timeout", 32'(guard < 200), 32'd1);
        tick();
        checkOutput("prog_final_PC", 32'(PC), 32'd21);

        $display("[TB] hold in FETCH at PC=3");
        applyStimulus(0);
        doReset();
        reset        = 1'b0;
        checkSpacing = 1'b0;
        guard        = 0;
        while (wbCount < 3 && guard < 100) begin tick(); guard++; end
        checkOutput("hold_setup_timeout", 32'(guard < 100), 32'd1);
        tick();
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("hold_IM_read", 32'(IM_read), 32'd0);
            checkOutput("hold_PC", 32'(PC), 32'd3);
            tick();
        end
        hold = 1'b0;
        #1;
        checkOutput("hold_release_IM_read", 32'(IM_read), 32'd1);
        checkOutput("hold_release_PC", 32'(PC), 32'd3);
        guard = 0;
        while (wbCount < 4 && guard < 20) begin tick(); guard++; end
        checkOutput("hold_done_timeout", 32'(guard < 20), 32'd1);
        tick();
        checkOutput("hold_done_PC", 32'(PC), 32'd4);

        $display("[TB] illegal sub-op and all-ones word");
        applyStimulus(0);
        imem[1] = vec(mk(OP_ALU1, 25'h000001F), 4'd0, 1'b0, 1'b1);
        imem[2] = vec(32'hFFFF_FFFF, 4'd0, 1'b0, 1'b1);
`ifdef CPU_HALT_EN
        imem[2].skip = 1'b1;
`endif
        doReset();
        reset = 1'b0;
`ifdef CPU_HALT_EN
        repeat (24) tick();
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_PC", 32'(PC), 32'd2);
        checkOutput("halt_IM_enable", 32'(IM_enable), 32'd0);
        checkOutput("halt_IM_read", 32'(IM_read), 32'd0);
        checkOutput("halt_wb_count", 32'(wbCount), 32'd1);
`else
        guard = 0;
        while (PC != 10'd4 && guard < 40) begin tick(); guard++; end
        checkOutput("illegal_timeout", 32'(guard < 40), 32'd1);
        checkOutput("illegal_wb_count", 32'(wbCount), 32'd2);
        checkOutput("illegal_halted", 32'(halted), 32'd0);
`endif

        $display("[TB] PC wrap and reset during EXEC");
        applyStimulus(0);
        doReset();
        reset        = 1'b0;
        checkSpacing = 1'b1;
        guard        = 0;
        while (wbCount < IM_DEPTH && guard < 4300) begin tick(); guard++; end
        checkOutput("wrap_timeout", 32'(guard < 4300), 32'd1);
        checkOutput("wrap_last_PC", 32'(PC), 32'd1023);
        tick();
        checkOutput("wrap_PC", 32'(PC), 32'd0);
        guard = 0;
        while (!exec_en && guard < 10) begin tick(); guard++; end
        checkOutput("exec_wait_timeout", 32'(guard < 10), 32'd1);
        reset = 1'b1;
        clearTracking();
        tick();
        checkOutput("rst_exec_PC", 32'(PC), 32'd0);
        checkOutput("rst_exec_IM_enable", 32'(IM_enable), 32'd0);
        checkOutput("rst_exec_wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst_exec_exec_en", 32'(exec_en), 32'd0);
        checkOutput("rst_exec_IM_read", 32'(IM_read), 32'd0);
        checkOutput("rst_exec_ir", ir, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("post_rst_IM_read", 32'(IM_read), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have parameter MemSize, default 10, meaning the PC / IM address width.
REQ-002 The block SHALL have parameter DataSize, default 32, meaning the instruction width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port instruction, input, DataSize, the IM read data, valid one cycle after IM_read.
REQ-006 The block SHALL have port hold, input, 1, a fetch stall request.
REQ-007 The block SHALL have port PC, output, MemSize, the IM address.
REQ-008 The block SHALL have ports IM_read, IM_write and IM_enable, each output, 1, the IM fetch, write and chip-enable strobes.
REQ-009 The block SHALL have port ir, output, DataSize, the latched instruction register.
REQ-010 The block SHALL have port alu_op, output, 4, the ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ROTR, 8 MOV.
REQ-011 The block SHALL have port imm_sel, output, 1, selecting the immediate operand when 1 and rb when 0.
REQ-012 The block SHALL have ports exec_en and wb_en, each output, 1, the ALU-execute and regfile-write strobes.
REQ-013 The block SHALL have ports illegal and halted, each output, 1, the status flags.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB (plus HALT, see REQ-030), each non-IDLE instruction state lasting one cycle (4 cycles per instruction with no hold).
REQ-015 IDLE SHALL go to FETCH unconditionally on the first cycle after reset deasserts.
REQ-016 In FETCH with hold=0, IM_read=1 and IM_enable=1, PC is unchanged, and the next state is DECODE.
REQ-017 In FETCH with hold=1, IM_read=0 and the FSM stays in FETCH; hold SHALL be ignored in every other state.
REQ-018 In DECODE, ir SHALL capture instruction at the cycle's end, and alu_op, imm_sel and illegal are decoded combinationally from ir (EXEC onward).
REQ-019 Decode, with opcode = ir[30:25]: 101000 ADDI gives ADD/imm; 101100 ORI gives OR/imm; 101011 XORI gives XOR/imm; 100010 MOVI gives MOV/imm.
REQ-020 Decode, for opcode 100000 (ALU_1), uses sub = ir[4:0]: 00000 ADD, 00001 SUB, 00010 AND, 00100 OR and 00011 XOR give imm_sel=0; 01000 SLLI, 01001 SRLI and 01011 ROTRI give imm_sel=1.
REQ-021 Any other opcode or sub-op SHALL set illegal=1 from EXEC through WB, with alu_op=0 and imm_sel=0.
REQ-022 In EXEC, exec_en SHALL be 1 for exactly one cycle, and 0 if illegal.
REQ-023 In WB, wb_en SHALL be 1 for exactly one cycle, and 0 if illegal.
REQ-024 At the end of WB, PC SHALL become PC+1 modulo 2^MemSize (1023 wraps to 0), and the next state is FETCH.
REQ-025 IM_write SHALL be constant 0.
REQ-026 IM_enable SHALL be 1 in FETCH, DECODE, EXEC and WB, and 0 in IDLE and HALT.
REQ-027 exec_en, wb_en and IM_read SHALL never be asserted in the same cycle.

Reset
REQ-028 While reset=1 at a clock edge, the next state SHALL be IDLE with PC=0, ir=0, and all strobes and flags 0, regardless of the current state (including mid-instruction, HALT, or hold=1).
REQ-029 A WB cycle coincident with reset SHALL NOT increment PC, and wb_en SHALL read 0 in the cycle after reset.

Configuration
REQ-030 With macro CPU_HALT_EN defined, an ir of all ones decoded in DECODE SHALL send the FSM to HALT after EXEC (no wb_en, PC not incremented), with halted=1 and all strobes 0 until reset.
REQ-031 Without CPU_HALT_EN, the HALT state and the halted logic SHALL be absent, halted is tied 0, and all ones decodes as illegal (REQ-021).

Verification
REQ-032 Reset for 3 cycles, then release with IM holding ADDI r0,r0,13 at address 0 -> IM_read=1 at cycle 2 after release, exec_en at cycle 4, wb_en at cycle 5, alu_op=0, imm_sel=1, PC=1 at cycle 6.
REQ-033 Run the 21-instruction program (ADDI, MOVI, ADD, SUB, AND, OR, XOR, SLLI, ROTRI, ORI, XORI, ...) -> exactly 21 wb_en pulses spaced 4 cycles apart, alu_op matching REQ-019/020 each time, PC=21 at the end.
REQ-034 Hold=1 for 5 cycles in FETCH at PC=3 -> IM_read stays 0 for those 5 cycles, then asserts once, PC stays 3, and the instruction completes normally.
REQ-035 ALU_1 instruction with sub=11111 -> illegal=1, exec_en=0, wb_en=0, and PC still increments.
REQ-036 PC preset to 1023 via a program of 1024 NOPs (SRLI r0,r0,0) -> PC wraps to 0 after the last WB; reset asserted during EXEC -> IDLE next cycle, PC=0, no wb_en.
REQ-037 With CPU_HALT_EN, instruction FFFFFFFF at PC=2 -> halted=1 from the cycle after EXEC, PC stays 2, and IM_enable=0 until reset; without the macro -> illegal=1 and PC=3.
